// File: rtl/regfile_sequencer.sv
// -----------------------------------------------------------------------------
// regfile_sequencer
//
// Multi-cycle sequencer that drives every input of the 4-entry register_file.
// One 8-bit ALU instruction is accepted at a time and walks through
// IDLE -> READ -> EXEC -> WRITE -> IDLE. The register_file writes data_in into
// data[rd] on every clock, so every cycle except WRITE points rd at rs1 and
// feeds op1 back to data_in. That rewrites a register with its own value.
//
// Instruction format: [7:6] op (00 ADD, 01 SUB, 10 AND, 11 XOR),
//                     [5:4] rd, [3:2] rs1, [1:0] rs2
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   instr_valid/ready valid/ready handshake for instr_data
//   instr_data [7:0]  instruction
//   rf_rs1/rs2/rd     register_file address outputs
//   rf_data_in [W]    register_file write data
//   rf_op1/op2 [W]    register_file read data
//   done              1-cycle pulse during the write-back cycle
//   flag_z, flag_c    zero and carry/borrow of the last retired instruction
//
// Optional feature (macro REGSEQ_PERF_EN):
//   cnt_clr           synchronous clear of retired_cnt; it takes priority over done
//   retired_cnt[15:0] count of retired instructions, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module regfile_sequencer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [7:0]   instr_data,
    output logic [1:0]   rf_rs1,
    output logic [1:0]   rf_rs2,
    output logic [1:0]   rf_rd,
    output logic [W-1:0] rf_data_in,
    input  logic [W-1:0] rf_op1,
    input  logic [W-1:0] rf_op2,
`ifdef REGSEQ_PERF_EN
    input  logic         cnt_clr,
    output logic [15:0]  retired_cnt,
`endif
    output logic         done,
    output logic         flag_z,
    output logic         flag_c
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        EXEC  = 2'd2,
        WRITE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_XOR = 2'd3
    } op_e;

    state_e         state_q, state_d;
    op_e            op_q, op_d;
    logic [1:0]     rd_q, rd_d;
    logic [1:0]     rs1_q, rs1_d;
    logic [1:0]     rs2_q, rs2_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic           c_q, c_d;
    logic           flag_z_q, flag_z_d;
    logic           flag_c_q, flag_c_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic [W:0]     sum;

    always_comb begin
        // NOTE: every signal assigned here gets a default first.
        // Otherwise a path that skips the assignment would infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        c_d      = c_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        sum      = {1'b0, a_q} + {1'b0, b_q};

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    op_d    = op_e'(instr_data[7:6]);
                    rd_d    = instr_data[5:4];
                    rs1_d   = instr_data[3:2];
                    rs2_d   = instr_data[1:0];
                    state_d = READ;
                end
            end
            READ: begin
                // Operands are sampled here.
                // With rd == rs1 or rd == rs2, the instruction uses the pre-write values.
                a_d     = rf_op1;
                b_d     = rf_op2;
                state_d = EXEC;
            end
            EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        res_d = sum[W-1:0];
                        c_d   = sum[W];
                    end
                    OP_SUB: begin
                        res_d = a_q - b_q;
                        c_d   = (a_q < b_q);
                    end
                    OP_AND: begin
                        res_d = a_q & b_q;
                        c_d   = 1'b0;
                    end
                    default: begin
                        res_d = a_q ^ b_q;
                        c_d   = 1'b0;
                    end
                endcase
                state_d = WRITE;
            end
            default: begin
                flag_z_d = (res_q == '0);
                flag_c_d = c_q;
                state_d  = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
        done_d  = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            c_q      <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments.
            // All flops then update together from the values the previous cycle computed.
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            c_q      <= c_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign instr_ready = ready_q;
    assign done        = done_q;
    assign flag_z      = flag_z_q;
    assign flag_c      = flag_c_q;
    assign rf_rs1      = rs1_q;
    assign rf_rs2      = rs2_q;

    // Outside WRITE, rd follows rs1 and data_in carries op1 back.
    // The unconditional register_file write then preserves every register.
    assign rf_rd       = (state_q == WRITE) ? rd_q  : rs1_q;
    assign rf_data_in  = (state_q == WRITE) ? res_q : rf_op1;

`ifdef REGSEQ_PERF_EN
    logic [15:0] retired_cnt_q, retired_cnt_d;

    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (cnt_clr) begin
            retired_cnt_d = '0;
        end else if (done_q) begin
            retired_cnt_d = retired_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt_q <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regfile_sequencer
//
// Bench for regfile_sequencer.
// A behavioural register_file sits around the DUT: reset values r0=0, r1=0,
// r2=1, r3=0, with a write of data_in into data[rd] on every clock.
// The expected state is a plain array of register values and flags.
// The bench updates it per instruction from the ALU rules.
// Inputs are driven, and outputs sampled, on the falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         instr_valid;
    logic         instr_ready;
    logic [7:0]   instr_data;
    logic [1:0]   rf_rs1, rf_rs2, rf_rd;
    logic [W-1:0] rf_data_in, rf_op1, rf_op2;
    logic         done, flag_z, flag_c;
`ifdef REGSEQ_PERF_EN
    logic         cnt_clr;
    logic [15:0]  retired_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .rf_rd       (rf_rd),
        .rf_data_in  (rf_data_in),
        .rf_op1      (rf_op1),
        .rf_op2      (rf_op2),
`ifdef REGSEQ_PERF_EN
        .cnt_clr     (cnt_clr),
        .retired_cnt (retired_cnt),
`endif
        .done        (done),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    // Behavioural register_file around the DUT
    logic [W-1:0] rf [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf[0] <= '0;
            rf[1] <= '0;
            rf[2] <= 16'd1;
            rf[3] <= '0;
        end else begin
            rf[rf_rd] <= rf_data_in;
        end
    end

    assign rf_op1 = rf[rf_rs1];
    assign rf_op2 = rf[rf_rs2];

    // Reference model state
    logic [W-1:0] mdl [4];
    logic         exp_z, exp_c;
    int           exp_cnt;
    time          acc_time;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s r%0d", tag, i), 32'(rf[i]), 32'(mdl[i]));
        end
    endtask

    task automatic model_reset();
        mdl[0]  = '0;
        mdl[1]  = '0;
        mdl[2]  = 16'd1;
        mdl[3]  = '0;
        exp_z   = 1'b0;
        exp_c   = 1'b0;
        exp_cnt = 0;
    endtask

    // Issue one instruction; entered and left on a falling edge with the DUT idle.
    // hold keeps instr_valid high with nxt presented after acceptance.
    // clr pulses cnt_clr during the done cycle.
    task automatic run(input logic [7:0] ins, input bit hold, input logic [7:0] nxt, input bit clr);
        logic [1:0]   rd, rs1, rs2;
        logic [W-1:0] a, b, res;
        logic         c;
        int           s;
        instr_valid = 1'b1;
        instr_data  = ins;
        check("ready before accept", 32'(instr_ready), 32'd1);
        @(posedge clk);
        acc_time = $time;
        rd  = ins[5:4];
        rs1 = ins[3:2];
        rs2 = ins[1:0];
        a   = mdl[rs1];
        b   = mdl[rs2];
        case (ins[7:6])
            2'd0: begin s = int'(a) + int'(b); res = s[15:0]; c = s[16]; end
            2'd1: begin res = a - b; c = (a < b); end
            2'd2: begin res = a & b; c = 1'b0; end
            default: begin res = a ^ b; c = 1'b0; end
        endcase
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                instr_valid = hold;
                instr_data  = hold ? nxt : 8'($urandom);
            end
            check($sformatf("ready busy c%0d", cyc), 32'(instr_ready), 32'd0);
            check($sformatf("done c%0d", cyc), 32'(done), 32'(cyc == 3));
            check($sformatf("flag_z hold c%0d", cyc), 32'(flag_z), 32'(exp_z));
            check($sformatf("flag_c hold c%0d", cyc), 32'(flag_c), 32'(exp_c));
            check_regs($sformatf("loopback c%0d", cyc));
            if (cyc == 3) begin
                check("wb rd", 32'(rf_rd), 32'(rd));
                check("wb data", 32'(rf_data_in), 32'(res));
`ifdef REGSEQ_PERF_EN
                cnt_clr = clr;
`endif
            end
        end
        @(negedge clk);
`ifdef REGSEQ_PERF_EN
        cnt_clr = 1'b0;
        exp_cnt = clr ? 0 : ((exp_cnt + 1) & 16'hFFFF);
        check("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
`endif
        mdl[rd] = res;
        exp_z   = (res == '0);
        exp_c   = c;
        check_regs("after wb");
        check("flag_z", 32'(flag_z), 32'(exp_z));
        check("flag_c", 32'(flag_c), 32'(exp_c));
        check("done after wb", 32'(done), 32'd0);
    endtask

    logic [7:0] prog [61];
    time        t_first;

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
`ifdef REGSEQ_PERF_EN
        cnt_clr     = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst ready", 32'(instr_ready), 32'd1);
        check("rst done", 32'(done), 32'd0);
        check("rst flag_z", 32'(flag_z), 32'd0);
        check("rst flag_c", 32'(flag_c), 32'd0);
        check("rst rs1", 32'(rf_rs1), 32'd0);
        check("rst rs2", 32'(rf_rs2), 32'd0);
        check("rst rd", 32'(rf_rd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_regs("idle after reset");

        // 1: ADD r1 = r2 + r2
        run(8'h1A, 1'b0, 8'h00, 1'b0);
        check("t1 r1", 32'(rf[1]), 32'd2);
        check("t1 flag_z", 32'(flag_z), 32'd0);
        check("t1 flag_c", 32'(flag_c), 32'd0);

        // 2: SUB r3 = r2 - r1 borrows, ADD r3 = r3 + r2 wraps to 0
        run(8'h79, 1'b0, 8'h00, 1'b0);
        check("t2 r3 sub", 32'(rf[3]), 32'h0000FFFF);
        check("t2 borrow", 32'(flag_c), 32'd1);
        run(8'h3E, 1'b0, 8'h00, 1'b0);
        check("t2 r3 wrap", 32'(rf[3]), 32'd0);
        check("t2 flag_z", 32'(flag_z), 32'd1);
        check("t2 flag_c", 32'(flag_c), 32'd1);

        // 3: XOR r2 = r2 ^ r2
        run(8'hEA, 1'b0, 8'h00, 1'b0);
        check("t3 r2", 32'(rf[2]), 32'd0);
        check("t3 flag_z", 32'(flag_z), 32'd1);
        check("t3 flag_c", 32'(flag_c), 32'd0);

        // 4: valid held high across two instructions
        run(8'h1A, 1'b1, 8'h79, 1'b0);
        t_first = acc_time;
        run(8'h79, 1'b0, 8'h00, 1'b0);
        check("t4 accept spacing", 32'(acc_time - t_first), 32'd40);

        // 5: reset during EXEC of ADD r1 = r2 + r2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = 8'h1A;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5 ready in reset", 32'(instr_ready), 32'd1);
        check("t5 done in reset", 32'(done), 32'd0);
        check("t5 rd in reset", 32'(rf_rd), 32'd0);
        @(negedge clk);
        check("t5 ready held", 32'(instr_ready), 32'd1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5 no done", 32'(done), 32'd0);
            check("t5 ready", 32'(instr_ready), 32'd1);
            check_regs("t5 no write");
        end
        check("t5 r1", 32'(rf[1]), 32'd0);

`ifdef REGSEQ_PERF_EN
        // 6: three retirements, then a clear that collides with the fourth done
        check("t6 cnt start", 32'(retired_cnt), 32'd0);
        run(8'h1A, 1'b0, 8'h00, 1'b0);
        run(8'h79, 1'b0, 8'h00, 1'b0);
        run(8'h3E, 1'b0, 8'h00, 1'b0);
        check("t6 cnt3", 32'(retired_cnt), 32'd3);
        run(8'hEA, 1'b0, 8'h00, 1'b1);
        check("t6 cnt clr", 32'(retired_cnt), 32'd0);
`endif

        // Random instruction stream, sometimes back to back
        for (int i = 0; i < 61; i++) begin
            prog[i] = 8'($urandom);
        end
        for (int i = 0; i < 60; i++) begin
            run(prog[i], (i < 59) && ($urandom_range(0, 1) == 1), prog[i+1],
                ($urandom_range(0, 7) == 0));
        end

        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
